fifo_word_reader: RTL
=====================

// Module: fifo_word_reader
// PURPOSE
//  Read side of the 8-bit byte FIFO: drains bytes through the FIFO's rd_en/empty/dout
//  interface and packs them little-endian into BYTES-wide words on a valid/ready stream.
//  Partial words are closed by an explicit flush or an idle timeout. Sits between the
//  byte FIFO and any word-wide consumer (DMA, bus bridge).
// PARAMETERS
//  BYTES    4   bytes per output word (2..8); m_data width = 8*BYTES
//  TIMEOUT  16  idle cycles with a partial word before auto-close (>=2)
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        reset, asynchronous, active-low
//  fifo_empty  in   1        FIFO empty flag
//  fifo_dout   in   8        FIFO read data, valid the cycle after an accepted read
//  fifo_rd_en  out  1        FIFO read enable (combinational)
//  flush       in   1        level request: close current partial word
//  m_data      out  8*BYTES  packed word; first byte in [7:0]
//  m_keep      out  BYTES    byte-lane valid mask, contiguous from lane 0
//  m_last      out  1        word was closed by flush
//  m_valid     out  1        word available
//  m_ready     in   1        consumer accepts word
// BEHAVIOUR
//  Reset (rst=0, async): state=FILL, held=0, pending=0, idle=0; m_data=0, m_keep=0,
//   m_last=0, m_valid=0; fifo_rd_en forced 0 while rst=0. Partial data is discarded.
//  States: FILL (collecting bytes), HOLD (m_valid=1, waiting for m_ready).
//  Accepted read: cycle N with fifo_rd_en=1 and fifo_empty=0; sets pending=1.
//  fifo_rd_en = (state==FILL) && !fifo_empty && (held+pending < BYTES) && !closing.
//   Back-to-back reads permitted; fifo_rd_en low throughout HOLD.
//  Capture: end of cycle N+1 when pending=1: fifo_dout -> lane[held], held+1,
//   pending cleared (or re-set by a new accepted read in N+1). fifo_dout never sampled
//   otherwise (FIFO drives it high-Z when not reading).
//  Word complete: capture makes held==BYTES -> HOLD next cycle, m_keep all ones,
//   m_last=0. Latency: last accepted read in cycle N -> m_valid=1 in cycle N+2.
//  Idle counter: in FILL with 0<held<BYTES, increments each cycle with no capture and
//   pending=0; clears on capture, on HOLD entry, and when held==0.
//  Timeout close: idle reaches TIMEOUT -> HOLD, m_keep=(1<<held)-1, m_last=0.
//  Flush close: flush=1, held>0 -> HOLD with m_keep per held, m_last=1. Flush and
//   timeout are deferred while pending=1 (closing=1 blocks new reads meanwhile), so
//   no in-flight byte is ever lost. flush with held==0 and pending==0: ignored.
//  Flush and timeout in same cycle: flush wins (m_last=1).
//  Unused lanes of m_data are 0.
//  HOLD: m_data/m_keep/m_last stable while m_valid=1 && m_ready=0. Handshake at edge
//   (m_valid&&m_ready) -> FILL, held=0, m_valid=0, m_keep=0; reads resume next cycle.
//  Width rules: held/pending counters sized $clog2(BYTES+1); idle sized
//   $clog2(TIMEOUT+1), saturates at TIMEOUT.
// TESTING
//  FIFO holds A1,A2,A3,A4, m_ready=1 -> rd_en 4 consecutive cycles; 2 cycles after last
//   read m_valid=1, m_data=32'hA4A3A2A1, m_keep=4'hF, m_last=0.
//  8 bytes queued, m_ready=0 for 5 cycles after first word -> word stable, rd_en=0 in
//   HOLD; after handshake second word follows in order.
//  Push B1,B2 then nothing -> 16 idle cycles later m_data=32'h0000B2B1, m_keep=4'h3,
//   m_last=0.
//  Three bytes C1..C3, flush asserted in same cycle as third read -> close deferred
//   until capture; m_data=32'h00C3C2C1, m_keep=4'h7, m_last=1. flush with empty
//   packer -> no m_valid.
//  fifo_empty toggling every cycle with D1..D4 -> no reads while empty, word
//   32'hD4D3D2D1, no duplicated/dropped bytes.
//  rst pulsed low after 2 bytes captured -> outputs reset immediately, rd_en=0; later
//   4 new bytes form a clean word with no stale lanes.

Source files
------------

// File: rtl/fifo_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_reader
//  Description : Read side of an 8-bit byte FIFO. Pulls bytes through the
//                FIFO's rd_en/empty/dout interface and packs them
//                little-endian into BYTES-wide words on a valid/ready
//                stream. A partial word is closed by a flush request (m_last=1)
//                or after TIMEOUT idle cycles (m_last=0).
//  Ports       : clk        - rising-edge clock
//                rst        - asynchronous reset, active low
//                fifo_empty - FIFO empty flag
//                fifo_dout  - FIFO read data, valid the cycle after a read
//                fifo_rd_en - FIFO read enable (combinational)
//                flush      - level request to close the current partial word
//                m_data     - packed word, first byte in [7:0], unused lanes 0
//                m_keep     - byte-lane valid mask, contiguous from lane 0
//                m_last     - word was closed by flush
//                m_valid    - word available
//                m_ready    - consumer accepts word
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_reader #(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_dout,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic [8*BYTES-1:0] m_data,
  output logic [BYTES-1:0]   m_keep,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready
);

  localparam int C_HW = $clog2(BYTES + 1);
  localparam int C_IW = $clog2(TIMEOUT + 1);
  localparam logic [C_HW:0]   C_BYTES   = (C_HW + 1)'(BYTES);
  localparam logic [C_IW-1:0] C_TIMEOUT = C_IW'(TIMEOUT);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [C_HW-1:0]   r_held;
  logic              r_pending;
  logic [C_IW-1:0]   r_idle;
  logic              r_closing;
  logic [BYTES-1:0]  r_keep;
  logic              r_last;
  logic [7:0]        r_lane [BYTES];

  logic              w_fill;
  logic [C_HW:0]     w_inflight;
  logic [C_HW:0]     w_held_inc;
  logic              w_word_full;
  logic              w_close_req;
  logic              w_close_now;
  logic              w_rd_en;
  logic              w_handshake;
  logic [BYTES-1:0]  w_close_keep;

  assign w_fill      = (r_state == FILL);
  assign w_inflight  = {1'b0, r_held} + {{C_HW{1'b0}}, r_pending};
  assign w_held_inc  = {1'b0, r_held} + {{C_HW{1'b0}}, 1'b1};
  // The in-flight byte lands this cycle and fills the last lane.
  assign w_word_full = w_fill && r_pending && (w_held_inc == C_BYTES);
  assign w_handshake = (r_state == HOLD) && m_ready;

  // A close is wanted on flush with anything collected or in flight, or on
  // idle expiry. It can only execute once no byte is in flight.
  assign w_close_req = (flush && ((r_held != '0) || r_pending)) || (r_idle == C_TIMEOUT);
  assign w_close_now = w_fill && !r_pending && w_close_req;

  // r_closing covers the cycles where a close is deferred behind an in-flight
  // byte; w_close_now covers the cycle the close itself executes.
  assign w_rd_en    = rst && w_fill && !fifo_empty && (w_inflight < C_BYTES)
                      && !r_closing && !w_close_now;
  assign fifo_rd_en = w_rd_en;

  always_comb begin
    w_close_keep = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_close_keep[i] = (i < int'(r_held));
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: if (w_word_full || w_close_now) w_next_state = HOLD;
      HOLD: if (m_ready)                    w_next_state = FILL;
      default:                              w_next_state = FILL;
    endcase
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held    <= '0;
      r_pending <= 1'b0;
      r_idle    <= '0;
      r_closing <= 1'b0;
      r_keep    <= '0;
      r_last    <= 1'b0;
    end else begin
      r_pending <= w_rd_en;
      r_closing <= w_fill && r_pending && w_close_req;

      if (r_pending) begin
        r_held <= r_held + 1'b1;
      end

      if (!w_fill || r_pending || (r_held == '0) || (w_next_state == HOLD)) begin
        r_idle <= '0;
      end else if (r_idle != C_TIMEOUT) begin
        r_idle <= r_idle + 1'b1;
      end

      if (w_word_full) begin
        r_keep <= '1;
        r_last <= 1'b0;
      end else if (w_close_now) begin
        r_keep <= w_close_keep;
        // Flush takes precedence when it coincides with a timeout.
        r_last <= flush;
      end

      if (w_handshake) begin
        r_held <= '0;
        r_keep <= '0;
        r_last <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- lanes
  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_lane[i] <= '0;
      end else if (w_handshake) begin
        r_lane[i] <= '0;
      end else if (r_pending && (r_held == C_HW'(i))) begin
        r_lane[i] <= fifo_dout;
      end
    end
    assign m_data[8*i +: 8] = r_lane[i];
  end

  assign m_keep  = r_keep;
  assign m_last  = r_last;
  assign m_valid = (r_state == HOLD);

endmodule
`default_nettype wire
